// File: rtl/stage_sequencer.sv
// stage_sequencer: launch-vehicle stage sequencer for the trajectory sim.
// Holds a per-entry table (Isp, initial weight, propellant weight, burntime,
// coast cycles) and presents one entry at a time to the getVelocity
// calculator. The calculator is held in reset everywhere except BURN. The
// sequencer advances on ignition_end and handles coast gaps, abort and a
// burn watchdog.
// Ports:
//   clk, resetb          clock, async active-low reset
//   start, abort         sequence start pulse, abort level
//   ignition_end         calculator burn-finished flag (honoured only in BURN)
//   cfg_we/stage/field/data, cfg_err   table write port and reject pulse
//   specific_impulse, initial_weight, propellant_weight, burntime
//                        current entry values, loaded in LOAD
//   calc_resetb          active-low reset to the calculator
//   stage_idx, burning, sep_pulse, done, aborted, fault, met_cycles  status
module stage_sequencer #(
    parameter int unsigned N           = 64,
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned SW          = 3,
    parameter int unsigned ARM_CYCLES  = 2,
    parameter int unsigned WDOG_CYCLES = 0
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          start,
    input  logic          abort,
    input  logic          ignition_end,
    input  logic          cfg_we,
    input  logic [SW-1:0] cfg_stage,
    input  logic [2:0]    cfg_field,
    input  logic [N-1:0]  cfg_data,
    output logic          cfg_err,
    output logic [N-1:0]  specific_impulse,
    output logic [N-1:0]  initial_weight,
    output logic [N-1:0]  propellant_weight,
    output logic [N-1:0]  burntime,
    output logic          calc_resetb,
    output logic [SW-1:0] stage_idx,
    output logic          burning,
    output logic          sep_pulse,
    output logic          done,
    output logic          aborted,
    output logic          fault,
    output logic [N-1:0]  met_cycles
);

    localparam int unsigned DEPTH = 1 << SW;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ARM   = 3'd2;
    localparam logic [2:0] S_BURN  = 3'd3;
    localparam logic [2:0] S_SEP   = 3'd4;
    localparam logic [2:0] S_COAST = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ABORT = 3'd7;

    localparam logic [SW:0]   NUM_ST   = (SW+1)'(NUM_STAGES);
    localparam logic [SW-1:0] LAST_IDX = SW'(NUM_STAGES - 1);

    // Table is sized to the full index space; entries >= NUM_STAGES are never written.
    logic [N-1:0] isp_tbl_q   [DEPTH];
    logic [N-1:0] iw_tbl_q    [DEPTH];
    logic [N-1:0] pw_tbl_q    [DEPTH];
    logic [N-1:0] bt_tbl_q    [DEPTH];
    logic [N-1:0] coast_tbl_q [DEPTH];

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [31:0]   arm_cnt_q, arm_cnt_d;
    logic [31:0]   wd_cnt_q, wd_cnt_d;
    logic [N-1:0]  coast_cnt_q, coast_cnt_d;
    logic [N-1:0]  met_q, met_d;
    logic          fault_q, fault_d;

    logic          cfg_err_q, burning_q, calc_resetb_q, sep_q, done_q, aborted_q;
    logic [N-1:0]  isp_q, iw_q, pw_q, bt_q;

    logic          active_c;
    logic          cfg_ok_c;

    assign active_c = !(state_q inside {S_IDLE, S_DONE, S_ABORT});
    assign cfg_ok_c = cfg_we && !active_c && ({1'b0, cfg_stage} < NUM_ST) && (cfg_field <= 3'd4);

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        arm_cnt_d   = arm_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        coast_cnt_d = coast_cnt_q;
        met_d       = met_q;
        fault_d     = fault_q;

        if (active_c && (met_q != '1)) begin
            met_d = met_q + N'(1);
        end

        case (state_q)
            S_IDLE, S_DONE, S_ABORT: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    met_d   = '0;
                    fault_d = 1'b0;
                end
            end
            S_LOAD: begin
                state_d   = S_ARM;
                arm_cnt_d = '0;
            end
            S_ARM: begin
                if (arm_cnt_q == ARM_CYCLES - 1) begin
                    state_d  = S_BURN;
                    wd_cnt_d = '0;
                end else begin
                    arm_cnt_d = arm_cnt_q + 32'd1;
                end
            end
            S_BURN: begin
                if (ignition_end) begin
                    state_d = S_SEP;
                end else if ((WDOG_CYCLES != 0) && (wd_cnt_q == WDOG_CYCLES - 1)) begin
                    state_d = S_ABORT;
                    fault_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
                end
            end
            S_SEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + SW'(1);
                    // Coast length belongs to the entry that just finished.
                    if (coast_tbl_q[idx_q] != '0) begin
                        state_d     = S_COAST;
                        coast_cnt_d = coast_tbl_q[idx_q];
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_COAST: begin
                if (coast_cnt_q <= N'(1)) begin
                    state_d = S_LOAD;
                end else begin
                    coast_cnt_d = coast_cnt_q - N'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over every other transition and freezes the entry index.
        if (active_c && abort) begin
            state_d = S_ABORT;
            idx_d   = idx_q;
            fault_d = fault_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            arm_cnt_q     <= '0;
            wd_cnt_q      <= '0;
            coast_cnt_q   <= '0;
            met_q         <= '0;
            fault_q       <= 1'b0;
            cfg_err_q     <= 1'b0;
            burning_q     <= 1'b0;
            calc_resetb_q <= 1'b0;
            sep_q         <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            isp_q         <= '0;
            iw_q          <= '0;
            pw_q          <= '0;
            bt_q          <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            arm_cnt_q     <= arm_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            coast_cnt_q   <= coast_cnt_d;
            met_q         <= met_d;
            fault_q       <= fault_d;
            cfg_err_q     <= cfg_we && !cfg_ok_c;
            burning_q     <= (state_d == S_BURN);
            calc_resetb_q <= (state_d == S_BURN);
            sep_q         <= (state_d == S_SEP);
            done_q        <= (state_d == S_DONE);
            aborted_q     <= (state_d == S_ABORT);
            if (state_q == S_LOAD) begin
                isp_q <= isp_tbl_q[idx_q];
                iw_q  <= iw_tbl_q[idx_q];
                pw_q  <= pw_tbl_q[idx_q];
                bt_q  <= bt_tbl_q[idx_q];
            end
        end
    end

    // Stage table; writes only while no sequence is running.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) begin
                isp_tbl_q[i]   <= '0;
                iw_tbl_q[i]    <= '0;
                pw_tbl_q[i]    <= '0;
                bt_tbl_q[i]    <= '0;
                coast_tbl_q[i] <= '0;
            end
        end else if (cfg_ok_c) begin
            case (cfg_field)
                3'd0:    isp_tbl_q[cfg_stage]   <= cfg_data;
                3'd1:    iw_tbl_q[cfg_stage]    <= cfg_data;
                3'd2:    pw_tbl_q[cfg_stage]    <= cfg_data;
                3'd3:    bt_tbl_q[cfg_stage]    <= cfg_data;
                3'd4:    coast_tbl_q[cfg_stage] <= cfg_data;
                default: ;
            endcase
        end
    end

    assign cfg_err           = cfg_err_q;
    assign specific_impulse  = isp_q;
    assign initial_weight    = iw_q;
    assign propellant_weight = pw_q;
    assign burntime          = bt_q;
    assign calc_resetb       = calc_resetb_q;
    assign stage_idx         = idx_q;
    assign burning           = burning_q;
    assign sep_pulse         = sep_q;
    assign done              = done_q;
    assign aborted           = aborted_q;
    assign fault             = fault_q;
    assign met_cycles        = met_q;

endmodule
